// File: rtl/hud_number_renderer.sv
`default_nettype none
// ============================================================================
// hud_number_renderer - redraws changed HUD number fields as decimal glyphs
// Revision: 1.0
// ============================================================================
module hud_number_renderer #(
  parameter int          N_FIELD   = 6,
  parameter int          VAL_W     = 16,
  parameter int          N_DIGIT   = 5,
  parameter int          GLYPH_W   = 8,
  parameter int          GLYPH_H   = 16,
  parameter int          FB_W      = 640,
  parameter int          ORIGIN_X  = 544,
  parameter int          ORIGIN_Y  = 32,
  parameter int          ROW_PITCH = 24,
  parameter logic [15:0] FG        = 16'hFFFF,
  parameter logic [15:0] BG        = 16'h0000,
  parameter int          GA_W      = $clog2(10*GLYPH_H)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_FIELD*VAL_W-1:0] values,
  input  logic                     refresh,
  output logic                     busy,
  output logic [GA_W-1:0]          glyph_addr,
  input  logic [GLYPH_W-1:0]       glyph_data,
  output logic [18:0]              dst_addr,
  output logic [15:0]              dst_data,
  output logic                     dst_wr,
  input  logic                     dst_ready
);
  localparam int FW = (N_FIELD > 1) ? $clog2(N_FIELD) : 1;
  localparam int DW = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;
  localparam int RW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int CW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int KW = $clog2(VAL_W + 1);
  localparam int BW = 4 * N_DIGIT;
  localparam logic [BW-1:0] ALL9 = {N_DIGIT{4'h9}};

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction
  localparam logic [63:0] MAX_VAL = pow10(N_DIGIT) - 64'd1;

  function automatic logic [GA_W-1:0] gaddr(input logic [BW-1:0] b, input int d, input int r);
    logic [3:0] n;
    n = b[4*(N_DIGIT-1-d) +: 4];
    return GA_W'(int'(n) * GLYPH_H + r);
  endfunction

  function automatic logic [18:0] paddr(input int f, input int r, input int d);
    return 19'((ORIGIN_Y + f*ROW_PITCH + r) * FB_W + ORIGIN_X + d*GLYPH_W);
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    CONV  = 3'd2,
    FETCH = 3'd3,
    LOAD  = 3'd4,
    WRITE = 3'd5
  } state_t;

  state_t              state_q;
  logic [VAL_W-1:0]    shadow_q [N_FIELD];
  logic [N_FIELD-1:0]  dirty_q, dirty_d;
  logic [FW-1:0]       field_q, sel;
  logic [VAL_W-1:0]    bin_q;
  logic [BW-1:0]       bcd_q, bcd_adj, bcd_step, bcd_fin;
  logic                bcd_ovf;
  logic                sat_q;
  logic [KW-1:0]       cnt_q;
  logic [DW-1:0]       digit_q, dig_nx;
  logic [RW-1:0]       row_q, row_nx;
  logic [CW-1:0]       col_q;
  logic [GLYPH_W-1:0]  pix_q;
  logic [GA_W-1:0]     glyph_addr_q;
  logic [18:0]         dst_addr_q;
  logic [15:0]         dst_data_q;
  logic                dst_wr_q;
  logic [N_DIGIT-1:0]  blank;
  logic                lead;
  logic [VAL_W-1:0]    vals [N_FIELD];
  logic                last_col, last_row, last_dig;

  always_comb begin
    for (int f = 0; f < N_FIELD; f++) vals[f] = values[f*VAL_W +: VAL_W];
  end

  always_comb begin
    sel = '0;
    for (int f = N_FIELD-1; f >= 0; f--) if (dirty_q[f]) sel = FW'(f);
  end

  // The field being scanned compares against its freshly latched value, so only refresh re-dirties it.
  always_comb begin
    dirty_d = '0;
    for (int f = 0; f < N_FIELD; f++)
      dirty_d[f] = refresh || (((state_q != SCAN) || (sel != FW'(f))) &&
                               (dirty_q[f] || (vals[f] != shadow_q[f])));
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < N_DIGIT; d++)
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
  end
  assign {bcd_ovf, bcd_step} = {bcd_adj, bin_q[VAL_W-1]};
  // Carry out of the top digit cannot occur for in-range values; treat it as saturation.
  assign bcd_fin = sat_q ? bcd_q : (bcd_ovf ? ALL9 : bcd_step);

  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int d = 0; d < N_DIGIT-1; d++) begin
      lead     = lead && (bcd_q[4*(N_DIGIT-1-d) +: 4] == 4'd0);
      blank[d] = lead;
    end
  end

  assign last_col = (col_q == CW'(GLYPH_W-1));
  assign last_row = (row_q == RW'(GLYPH_H-1));
  assign last_dig = (digit_q == DW'(N_DIGIT-1));
  assign row_nx   = last_row ? '0 : row_q + RW'(1);
  assign dig_nx   = last_row ? digit_q + DW'(1) : digit_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      dirty_q      <= '1;
      for (int f = 0; f < N_FIELD; f++) shadow_q[f] <= '0;
      field_q      <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      sat_q        <= 1'b0;
      cnt_q        <= '0;
      digit_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      pix_q        <= '0;
      glyph_addr_q <= '0;
      dst_addr_q   <= '0;
      dst_data_q   <= '0;
      dst_wr_q     <= 1'b0;
    end else begin
      dirty_q <= dirty_d;
      case (state_q)
        IDLE: if (|dirty_q) state_q <= SCAN;
        SCAN: begin
          field_q        <= sel;
          shadow_q[sel]  <= vals[sel];
          bin_q          <= vals[sel];
          sat_q          <= (64'(vals[sel]) > MAX_VAL);
          bcd_q          <= (64'(vals[sel]) > MAX_VAL) ? ALL9 : '0;
          cnt_q          <= '0;
          state_q        <= CONV;
        end
        CONV: begin
          if (!sat_q) begin
            bcd_q <= bcd_fin;
            bin_q <= bin_q << 1;
            sat_q <= bcd_ovf;
          end
          cnt_q <= cnt_q + KW'(1);
          if (cnt_q == KW'(VAL_W-1)) begin
            digit_q      <= '0;
            row_q        <= '0;
            glyph_addr_q <= gaddr(bcd_fin, 0, 0);
            state_q      <= FETCH;
          end
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          pix_q      <= glyph_data << 1;
          col_q      <= '0;
          dst_wr_q   <= 1'b1;
          dst_addr_q <= paddr(int'(field_q), int'(row_q), int'(digit_q));
          dst_data_q <= (glyph_data[GLYPH_W-1] && !blank[digit_q]) ? FG : BG;
          state_q    <= WRITE;
        end
        WRITE: if (dst_ready) begin
          if (last_col) begin
            dst_wr_q <= 1'b0;
            row_q    <= row_nx;
            digit_q  <= dig_nx;
            if (last_row && last_dig) begin
              state_q <= IDLE;
            end else begin
              glyph_addr_q <= gaddr(bcd_q, int'(dig_nx), int'(row_nx));
              state_q      <= FETCH;
            end
          end else begin
            col_q      <= col_q + CW'(1);
            dst_addr_q <= dst_addr_q + 19'd1;
            dst_data_q <= (pix_q[GLYPH_W-1] && !blank[digit_q]) ? FG : BG;
            pix_q      <= pix_q << 1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign glyph_addr = glyph_addr_q;
  assign dst_addr   = dst_addr_q;
  assign dst_data   = dst_data_q;
  assign dst_wr     = dst_wr_q;

endmodule
`default_nettype wire

// File: doc/hud_number_renderer.md
# hud_number_renderer

Parametrised HUD number renderer. It watches N_FIELD unsigned values (floor, health, key counts, …) and redraws only the fields that have changed. Each redrawn field is converted to decimal with a sequential double-dabble, leading zeros are blanked, and the digit glyph rows are fetched from an external glyph ROM. Pixels go into the framebuffer write port with ready/valid backpressure. It sits between game-state registers and the framebuffer arbiter, in the slot of the fixed-layout number block.

## Interface
- N_FIELD, 6, number of displayed fields, drawn one per text row.
- VAL_W, 16, width of each field value.
- N_DIGIT, 5, decimal digits per field.
- GLYPH_W, 8, glyph width in pixels.
- GLYPH_H, 16, glyph height in pixels.
- FB_W, 640, framebuffer line pitch in pixels.
- ORIGIN_X, 544, left pixel of digit 0 (the most significant digit).
- ORIGIN_Y, 32, top pixel of field 0.
- ROW_PITCH, 24, vertical distance between fields, in pixels.
- FG, 16'hFFFF, foreground colour.
- BG, 16'h0000, background colour.
- GA_W, $clog2(10*GLYPH_H), glyph address width (derived).
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- values  in  N_FIELD*VAL_W  field f is at [f*VAL_W +: VAL_W].
- refresh  in  1  single-cycle pulse; marks every field dirty.
- busy  out  1  high whenever state ≠ IDLE.
- glyph_addr  out  GA_W  address = digit*GLYPH_H + row.
- glyph_data  in  GLYPH_W  glyph row, valid 1 cycle after glyph_addr; bit GLYPH_W-1 is column 0.
- dst_addr  out  19  framebuffer pixel address.
- dst_data  out  16  pixel colour.
- dst_wr  out  1  write request.
- dst_ready  in  1  framebuffer accepts the write.

## Operation
- **Change detection.** The block keeps a shadow copy of the last value drawn for each field, plus a dirty bit per field.
  - Each cycle, dirty[f] is set if values[f] ≠ shadow[f], or if refresh is high.
- **IDLE.** Go to SCAN if any dirty bit is set.
- **SCAN (1 cycle).** Select the lowest-index dirty field f.
  - Latch values[f] into the work register and into shadow[f].
  - Clear dirty[f]. If the same cycle also sets it, set wins and the field is drawn again later.
- **Saturation.** If the latched value > 10^N_DIGIT−1, load the constant of all-9 BCD digits instead.
- **CONV (VAL_W cycles).** Double-dabble into 4*N_DIGIT BCD bits: for each digit ≥5, add 3, then shift left 1.
  - Blank mask: digit d is blank if it and every digit to its left are 0, except digit N_DIGIT−1, which is never blank. A value of 0 shows a single "0".
- **FETCH (1 cycle).** Drive glyph_addr for the current (digit, row). Go to LOAD.
- **LOAD (1 cycle).** Capture glyph_data into the row shift register. Go to WRITE.
- **WRITE.** Per column (col 0..GLYPH_W−1):
  - dst_data = FG if the pixel bit is 1 and the digit is not blank, else BG.
  - dst_addr = (ORIGIN_Y + f*ROW_PITCH + row)*FB_W + ORIGIN_X + d*GLYPH_W + col, where d=0 is the leftmost (most significant) digit.
- **Draw order.** Columns advance only on dst_wr && dst_ready.
  - After the last column, go to the next row (back to FETCH).
  - After row GLYPH_H−1, go to the next digit.
  - After the last digit, return to IDLE; if anything is dirty, IDLE moves on to SCAN in the next cycle.
- **Value changes mid-draw.** A field changing while it is being drawn does not disturb the current pass. It becomes dirty again and is redrawn after.
- **refresh mid-draw.** The current field completes, then every field is redrawn in index order.

## Timing
- **Reset values** (asynchronous on rstn low):
  - state = IDLE; busy, dst_wr, dst_addr, dst_data and glyph_addr = 0.
  - shadow = 0; all dirty bits = 1, so the full HUD is drawn after reset.
- **Reset mid-operation.** dst_wr drops immediately and no partial state survives.
- **Write handshake.**
  - dst_wr, dst_addr and dst_data are registered.
  - While dst_wr=1 and dst_ready=0, all three hold stable.
  - dst_wr is never deasserted without acceptance, except by reset.
- **Glyph ROM.** Fixed 1-cycle read latency. glyph_addr holds through LOAD.
- **Cycles per field with dst_ready=1:** 1 + VAL_W + N_DIGIT*GLYPH_H*(2+GLYPH_W). With the defaults this is 1+16+5*16*10 = 817.
- **Throughput.** At most one pixel is written per cycle; dst_wr is low during SCAN, CONV, FETCH and LOAD.

## Test plan
- **Reset draw.** Release rstn with values = {0,0,0,0,0,42} (field 0 = 42) -> all 6 fields are drawn, field 0 first.
  - First write: dst_addr = 21024, pixel = BG (digit 0 is blank).
  - Digits 3–4 of field 0 show glyphs "4" and "2"; digits 0–2 are all BG.
  - Total writes = 6*5*16*8 = 3840, then busy falls.
- **Selective redraw.** From idle, change field 2 to 7 -> exactly 640 writes.
  - Every address has y in 80..95.
  - The pixel at digit 1, row 5, col 3 has dst_addr = 54955 and colour BG.
- **Saturation.** With N_DIGIT=4, set a field to 12345 -> glyph_addr sequence shows digit 9 for all 4 digits.
  - Value 0 -> only digit 3 is fetched as "0"; the others are blank.
- **Backpressure.** Hold dst_ready low for 5 cycles mid-row -> dst_wr, dst_addr and dst_data stay constant.
  - No pixel is skipped or duplicated; the total write count is unchanged.
- **Mid-draw change and refresh.**
  - Change field 1 while field 1 is being drawn -> field 1 is drawn a second time with the new value.
  - Pulse refresh during field 3 -> field 3 completes, then fields 0..5 are redrawn in order.
- **Reset mid-draw.** Assert rstn low during WRITE -> dst_wr=0 in the same cycle. After release, the full-HUD draw restarts from field 0.
